// File: rtl/oled_spi_receiver_pkg.sv
// Shared types and constants for the OLED SPI receive path.
package oled_spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    END    = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
    logic       first;
  } fifo_entry_t;

endpackage

// File: rtl/oled_spi_receiver_fifo.sv
// Small synchronous FIFO; head entry is read straight from registered storage.
module oled_byte_fifo
  import oled_spi_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fifo_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// SPI mode-0 slave deserializer for the OLED command link.
//
// state  | meaning
// IDLE   | waiting for a cs_n high-to-low transition
// ACTIVE | frame open, shifting bits on sclk rising edges
// END    | one cycle: report frame, flag partial byte
module oled_spi_receiver
  import oled_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdi,
  input  logic       cs_n,
  input  logic       dc,
  output logic [7:0] m_data,
  output logic       m_dc,
  output logic       m_first,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_done,
  output logic [7:0] frame_bytes,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_sdi_sync, r_cs_sync, r_dc_sync;
  logic        r_sclk_hist, r_cs_hist;
  rx_state_t   r_state;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_byte_cnt;
  logic        r_first;
  logic        r_frame_done;
  logic [7:0]  r_frame_bytes;
  logic        r_frame_err;
  logic        r_overflow;

  logic        w_sclk_s, w_sdi_s, w_cs_s, w_dc_s;
  logic        w_sclk_rise, w_cs_fall, w_cs_rise;
  logic        w_shift, w_byte_done, w_pop, w_drop, w_full, w_empty;
  fifo_entry_t w_push_data, w_head;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_dc_s      = r_dc_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s && !r_sclk_hist;
  assign w_cs_fall   = !w_cs_s && r_cs_hist;
  assign w_cs_rise   = w_cs_s && !r_cs_hist;

  // a cs_n rise wins over an sclk edge in the same cycle
  assign w_shift     = (r_state == ACTIVE) && !w_cs_rise && !w_cs_s && w_sclk_rise;
  assign w_byte_done = w_shift && (r_bitcnt == 3'(SPI_BITS - 1));
  assign w_push_data = '{data: {r_shreg[6:0], w_sdi_s}, dc: w_dc_s, first: r_first};
  assign w_pop       = !w_empty && m_ready;
  assign w_drop      = w_byte_done && w_full && !w_pop;

  // synchronizers reset low, so cs_n already low at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      r_cs_sync   <= '0;
      r_dc_sync   <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dc};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
    end
  end

  // frame state machine and byte assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_byte_cnt <= '0;
      r_first    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_byte_cnt <= '0;
            r_first    <= 1'b1;
            r_state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            r_state <= END;
          end else if (w_shift) begin
            r_shreg  <= {r_shreg[6:0], w_sdi_s};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_byte_done) begin
              r_first <= 1'b0;
              if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
        end
        END:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // frame report, loaded once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done  <= 1'b0;
      r_frame_bytes <= '0;
    end else begin
      r_frame_done <= (r_state == END);
      if (r_state == END) r_frame_bytes <= r_byte_cnt;
    end
  end

  // sticky error flags; a new error beats clr_err in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if ((r_state == END) && (r_bitcnt != 3'd0)) r_frame_err <= 1'b1;
      else if (clr_err)                           r_frame_err <= 1'b0;
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
    end
  end

  oled_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_byte_done),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_data      = w_head.data;
  assign m_dc        = w_head.dc;
  assign m_first     = w_head.first;
  assign m_valid     = !w_empty;
  assign frame_done  = r_frame_done;
  assign frame_bytes = r_frame_bytes;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign busy        = (r_state == ACTIVE);

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Bench for oled_spi_receiver: SPI master model plus a scoreboard on the output stream.
module tb_oled_spi_receiver;
  import oled_spi_pkg::*;

  localparam int HALF = 100;   // clk cycles per sclk half period (sclk = clk/200)
  localparam int SYNC = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, sdi = 1'b0, cs_n = 1'b1, dc = 1'b0;
  logic       m_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] m_data, frame_bytes;
  logic       m_dc, m_first, m_valid, frame_done, frame_err, overflow, busy;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [9:0] exp_q[$];

  oled_spi_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .dc(dc),
    .m_data(m_data), .m_dc(m_dc), .m_first(m_first), .m_valid(m_valid),
    .m_ready(m_ready), .frame_done(frame_done), .frame_bytes(frame_bytes),
    .frame_err(frame_err), .overflow(overflow), .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // count frame_done pulses
  always @(negedge clk) if (frame_done) done_cnt++;

  // scoreboard: every accepted head entry must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_unexpected: got %h/%b/%b, wanted no entry", m_data, m_dc, m_first);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({m_data, m_dc, m_first} !== e) begin
          fails++;
          $display("FAIL stream_entry: got %h/%b/%b, wanted %h/%b/%b",
                   m_data, m_dc, m_first, e[9:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic dcv, input int nbits);
    dc = dcv;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = b[i];
      wclk(HALF);
      sclk = 1'b1;
      wclk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wclk(HALF);
  endtask

  task automatic end_frame(output bit got);
    int s;
    s = done_cnt;
    wclk(HALF);
    cs_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_cnt != s) begin
        got = 1'b1;
        break;
      end
    end
    wclk(2);
  endtask

  task automatic test_reset();
    wclk(3);
    tests++;
    if ({m_data, m_dc, m_first, m_valid, frame_done, frame_bytes, frame_err, overflow, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h valid=%b done=%b bytes=%h err=%b ovf=%b busy=%b, wanted all 0",
               m_data, m_valid, frame_done, frame_bytes, frame_err, overflow, busy);
    end
    rst_n = 1'b1;
    wclk(10);
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || done_cnt != 0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b valid=%b done_cnt=%0d, wanted 0 0 0", busy, m_valid, done_cnt);
    end
  endtask

  task automatic test_single();
    bit got;
    int lat;
    m_ready = 1'b0;
    start_frame();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy: got %b, wanted 1", busy);
    end
    exp_q.push_back({8'hAF, 1'b0, 1'b1});
    spi_bits(8'hAF, 1'b0, 7);
    sdi = 1'b1;
    wclk(HALF);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early_valid: got %b, wanted 0", m_valid);
    end
    sclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat == 0) begin
      fails++;
      $display("FAIL single_latency: got no m_valid within %0d cycles, wanted valid", SYNC + 2);
    end
    wclk(HALF);
    sclk = 1'b0;
    end_frame(got);
    tests++;
    if (!got || frame_bytes !== 8'd1 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL single_frame: got done=%b bytes=%0d err=%b, wanted 1 1 0", got, frame_bytes, frame_err);
    end
    m_ready = 1'b1;
    wclk(5);
    tests++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: got pending=%0d valid=%b, wanted 0 0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_multi();
    bit got;
    logic [7:0] b[3] = '{8'h81, 8'h7F, 8'hA5};
    logic       d[3] = '{1'b0, 1'b1, 1'b1};
    m_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({b[i], d[i], (i == 0)});
      spi_bits(b[i], d[i], 8);
    end
    end_frame(got);
    tests++;
    if (!got || frame_bytes !== 8'd3 || frame_err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL multi_frame: got done=%b bytes=%0d err=%b pending=%0d, wanted 1 3 0 0",
               got, frame_bytes, frame_err, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit got;
    logic [7:0] b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    m_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back({b[i], 1'b1, (i == 0)});
      spi_bits(b[i], 1'b1, 8);
    end
    end_frame(got);
    tests++;
    if (!got || frame_bytes !== 8'd6 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_frame: got done=%b bytes=%0d ovf=%b, wanted 1 6 1", got, frame_bytes, overflow);
    end
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h11 || m_first !== 1'b1) begin
      fails++;
      $display("FAIL ovf_head_hold: got valid=%b data=%h first=%b, wanted 1 11 1", m_valid, m_data, m_first);
    end
    m_ready = 1'b1;
    wclk(10);
    tests++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drain: got pending=%0d valid=%b, wanted 0 0", exp_q.size(), m_valid);
    end
    clr_err = 1'b1;
    wclk(1);
    clr_err = 1'b0;
    wclk(1);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b, wanted 0", overflow);
    end
  endtask

  task automatic test_partial();
    bit got;
    m_ready = 1'b1;
    start_frame();
    spi_bits(8'hC5, 1'b1, 5);
    end_frame(got);
    tests++;
    if (!got || frame_err !== 1'b1 || frame_bytes !== 8'd0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL partial_frame: got done=%b err=%b bytes=%0d valid=%b, wanted 1 1 0 0",
               got, frame_err, frame_bytes, m_valid);
    end
    clr_err = 1'b1;
    wclk(1);
    clr_err = 1'b0;
    wclk(1);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL partial_clear: got %b, wanted 0", frame_err);
    end
  endtask

  task automatic test_zero_frame();
    bit got;
    start_frame();
    end_frame(got);
    tests++;
    if (!got || frame_bytes !== 8'd0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_frame: got done=%b bytes=%0d err=%b busy=%b, wanted 1 0 0 0",
               got, frame_bytes, frame_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int s;
    m_ready = 1'b1;
    cs_n = 1'b0;
    wclk(HALF);
    spi_bits(8'hF0, 1'b0, 4);
    rst_n = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(5);
    s = done_cnt;
    spi_bits(8'hA0, 1'b0, 4);
    spi_bits(8'hEE, 1'b0, 8);
    wclk(HALF);
    cs_n = 1'b1;
    wclk(40);
    tests++;
    if (done_cnt != s || m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ignored: got done_pulses=%0d valid=%b busy=%b, wanted 0 0 0",
               done_cnt - s, m_valid, busy);
    end
    start_frame();
    exp_q.push_back({8'h3C, 1'b1, 1'b1});
    spi_bits(8'h3C, 1'b1, 8);
    end_frame(got);
    tests++;
    if (!got || frame_bytes !== 8'd1 || frame_err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_next: got done=%b bytes=%0d err=%b pending=%0d, wanted 1 1 0 0",
               got, frame_bytes, frame_err, exp_q.size());
    end
  endtask

  task automatic test_loopback();
    bit got;
    logic [7:0] cmd[2] = '{8'h15, 8'h00};
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_frame();
      exp_q.push_back({cmd[i], 1'b0, 1'b1});
      spi_bits(cmd[i], 1'b0, 8);
      end_frame(got);
      tests++;
      if (!got || frame_bytes !== 8'd1 || exp_q.size() != 0) begin
        fails++;
        $display("FAIL loopback_byte%0d: got done=%b bytes=%0d pending=%0d, wanted 1 1 0",
                 i, got, frame_bytes, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_partial();
    test_zero_frame();
    test_reset_mid();
    test_loopback();
    wclk(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
Name: oled_spi_receiver

Overview:
- SPI slave deserializer: the receiving (display) end of the OLED SPI command link; SPI mode 0, MSB first, frames delimited by cs_n.
- Oversamples sclk, sdi, cs_n and dc in the clk domain, assembles bytes, and buffers them in a small FIFO behind a valid/ready stream.
- Reports per-frame completion, byte count and framing/overflow errors.
- Used as the loopback/bench model of the panel and as the front end of an on-chip display emulator.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, >= 2.
- SYNC_STAGES, 2, synchronizer flops per async input; >= 2.

Ports:
- clk  in  1  system clock; frequency must be >= 4x the sclk frequency.
- rst_n  in  1  reset; asynchronous, active-low.
- sclk  in  1  SPI clock, async to clk; sampled on its rising edge.
- sdi  in  1  serial data, MSB first.
- cs_n  in  1  chip select, active-low; delimits frames.
- dc  in  1  data/command select; sampled with bit 0 of each byte.
- m_data  out  8  received byte at FIFO head.
- m_dc  out  1  dc captured with m_data.
- m_first  out  1  m_data is the first byte of its frame.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head when m_valid && m_ready.
- frame_done  out  1  one-cycle pulse when a frame ends.
- frame_bytes  out  8  complete bytes in the last frame; saturates at 255; held until the next frame_done.
- frame_err  out  1  sticky: a frame ended with a partial byte.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_err  in  1  synchronous clear of frame_err and overflow.
- busy  out  1  state == ACTIVE.

Behaviour:
- Reset: all outputs are 0; FIFO is empty; state is IDLE.
- Reset values of the synchronizer chains:
  - sclk, cs_n and their history registers reset to 0.
  - Consequence: cs_n already low at reset release produces no falling edge. The block waits for the next high-to-low transition, so a frame in progress at reset is ignored.
- Synchronize sclk, sdi, cs_n and dc through SYNC_STAGES flops. Edge detection compares the last sync stage with one history flop.
- State machine:
  - IDLE: on a cs_n_s falling edge, clear the shift register, bitcnt (3b) and frame byte counter; set first_pending=1; go to ACTIVE.
  - ACTIVE, on an sclk_s rising edge while cs_n_s==0:
    - shreg <= {shreg[6:0], sdi_s}; bitcnt++.
    - When bitcnt==7: push {byte, dc_s, first_pending}; first_pending <= 0; byte counter++ (saturating, counted even if the byte is dropped); bitcnt wraps to 0.
  - ACTIVE, on cs_n_s rising: go to END. An sclk edge in the same cycle is ignored.
  - END, for one cycle:
    - Pulse frame_done; load frame_bytes.
    - If bitcnt != 0, set frame_err and discard the partial byte.
    - Return to IDLE.
- Latency: byte visible on m_data with m_valid=1 no more than SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
- FIFO behaviour:
  - Registered outputs.
  - Push into an empty FIFO gives m_valid=1 the next cycle.
  - Push while full with no pop in that cycle: byte dropped, overflow set.
  - Push while full with a pop in the same cycle: push accepted, no overflow.
  - Simultaneous push and pop when not empty: occupancy unchanged.
  - m_data, m_dc and m_first are stable while m_valid && !m_ready.
- clr_err and a new error in the same cycle: the error wins (flag stays 1).
- Zero-byte frame (cs_n pulse with no sclk): frame_done with frame_bytes=0, no error.
- busy=0 in IDLE and END.

Decomposition:
- Package oled_spi_pkg:
  - state typedef rx_state_t {IDLE, ACTIVE, END};
  - FIFO entry struct {data[7:0], dc, first};
  - constant SPI_BITS=8.
- Sub-module oled_byte_fifo: parameterized synchronous FIFO, DEPTH and entry type, with full/empty flags.

Test Plan:
- Drive cs_n low, send 0xAF with dc=0, cs_n high, at sclk = clk/200 -> one entry: m_data=0xAF, m_dc=0, m_first=1. Then frame_done with frame_bytes=1, frame_err=0.
- 3-byte frame 0x81, 0x7F, 0xA5 with m_ready=1 -> three entries in order; m_first=1,0,0; frame_bytes=3.
- Hold m_ready=0; send 6 bytes in one frame (FIFO_DEPTH=4) -> first 4 bytes retained; overflow=1; frame_bytes=6. Pulse clr_err -> overflow=0.
- Send 5 bits then raise cs_n -> no FIFO push; frame_err=1; frame_bytes=0.
- Assert rst_n mid-byte with cs_n held low, release, finish the frame -> no bytes pushed. The next full frame with 0x3C is received correctly.
- Loopback with oledSPIcontroller: numbytes=2, cmd = 0x15, 0x00 -> two single-byte frames (cs_n toggles per byte), each giving frame_done with frame_bytes=1; data 0x15 then 0x00.
